gpsdc_trip_acc: RTL

GPSDC_TRIP_ACC -- requirements
Module: gpsdc_trip_acc

---
 rtl/gpsdc_trip_acc.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/gpsdc_trip_acc.sv
// GPS distance trip accumulator.
// Sums accepted segment distances per trip, tracks the largest segment and
// its index, and counts rejected (glitch) segments. Samples that arrive while
// a report is pending are held in a 2-entry buffer and replayed into the next
// trip once the report is acknowledged.
module gpsdc_trip_acc #(
  parameter logic [39:0] JUMP_TH = 40'hFF_FFFF_FFFF,
  parameter int unsigned TOT_W   = 48
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             D_VALID,
  input  logic [39:0]      D_IN,
  input  logic             TRIP_END,
  input  logic             ACK,
  output logic             RPT_VALID,
  output logic [TOT_W-1:0] TOTAL,
  output logic [15:0]      SEG_CNT,
  output logic [39:0]      MAX_D,
  output logic [15:0]      MAX_IDX,
  output logic [7:0]       GLITCH_CNT,
  output logic             OVF
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_REPORT} state_t;

  state_t      state, state_n;
  logic [39:0] fifo [2];
  logic [1:0]  fifo_cnt;
  logic        end_pend, end_pend_n;

  logic        smp_vld;
  logic [39:0] smp;
  logic        pop, push, push_ok, drop, clr, close;
  logic        end_req, accepted;
  logic [TOT_W:0]   sum_ext;
  logic [TOT_W-1:0] tot_next;

  assign RPT_VALID = (state == S_REPORT);

  // Next-state, sample source selection and buffer control.
  // While the buffer holds entries, its head is the sample of the cycle and
  // any new D_VALID is appended behind it; a trip end is held back until the
  // last buffered entry is applied, closing on that same edge.
  always_comb begin
    state_n    = state;
    end_pend_n = end_pend;
    smp_vld    = 1'b0;
    smp        = D_IN;
    pop        = 1'b0;
    push       = 1'b0;
    clr        = 1'b0;
    close      = 1'b0;
    end_req    = 1'b0;
    accepted   = 1'b0;
    case (state)
      S_REPORT: begin
        push = D_VALID;
        if (ACK) begin
          clr     = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: begin
        if (fifo_cnt != 2'd0) begin
          pop     = 1'b1;
          smp_vld = 1'b1;
          smp     = fifo[0];
          push    = D_VALID;
        end else begin
          smp_vld = D_VALID;
        end
        end_req  = TRIP_END | end_pend;
        accepted = smp_vld && (smp <= JUMP_TH);
        if (end_req) begin
          if (fifo_cnt == 2'd0 || (fifo_cnt == 2'd1 && !D_VALID))
            close = 1'b1;
          else
            end_pend_n = 1'b1;
        end
        if (close) begin
          state_n    = S_REPORT;
          end_pend_n = 1'b0;
        end else if (accepted) begin
          state_n = S_ACC;
        end
      end
    endcase
    push_ok = push && (pop || fifo_cnt != 2'd2);
    drop    = push && !pop && (fifo_cnt == 2'd2);
  end

  // Saturating total for the current sample.
  always_comb begin
    sum_ext  = {1'b0, TOTAL} + {{(TOT_W-39){1'b0}}, smp};
    tot_next = sum_ext[TOT_W] ? '1 : sum_ext[TOT_W-1:0];
  end

  // FSM state and deferred trip-end flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      end_pend <= 1'b0;
    end else begin
      state    <= state_n;
      end_pend <= end_pend_n;
    end
  end

  // Pending-sample buffer; entry 0 is always the head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo[0]  <= '0;
      fifo[1]  <= '0;
      fifo_cnt <= '0;
    end else begin
      case ({pop, push_ok})
        2'b01: begin
          fifo[fifo_cnt[0]] <= D_IN;
          fifo_cnt          <= fifo_cnt + 2'd1;
        end
        2'b10: begin
          fifo[0]  <= fifo[1];
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            fifo[0] <= D_IN;
          end else begin
            fifo[0] <= fifo[1];
            fifo[1] <= D_IN;
          end
        end
        default: ;
      endcase
    end
  end

  // Trip accumulators and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      TOTAL      <= '0;
      SEG_CNT    <= '0;
      MAX_D      <= '0;
      MAX_IDX    <= '0;
      GLITCH_CNT <= '0;
      OVF        <= 1'b0;
    end else begin
      if (drop)
        OVF <= 1'b1;
      if (clr) begin
        TOTAL      <= '0;
        SEG_CNT    <= '0;
        MAX_D      <= '0;
        MAX_IDX    <= '0;
        GLITCH_CNT <= '0;
      end else if (smp_vld) begin
        if (smp > JUMP_TH) begin
          if (GLITCH_CNT != 8'hFF)
            GLITCH_CNT <= GLITCH_CNT + 8'd1;
        end else begin
          TOTAL <= tot_next;
          if (SEG_CNT != 16'hFFFF)
            SEG_CNT <= SEG_CNT + 16'd1;
          if (smp > MAX_D) begin
            MAX_D   <= smp;
            MAX_IDX <= SEG_CNT;
          end
        end
      end
    end
  end

endmodule
